ccw_sequencer: RTL and testbench
================================

# ccw_sequencer

Executes a short channel program of chained CCWs against the `channel` block: fetches each CCW from a local program store, drives `channel`'s address/command/start/stop, and gates and counts the byte streams between a host-side data port and the channel. The block decides when a transfer is exhausted, evaluates ending status, and chains to the next CCW or terminates with a residual count and error flags. It sits between the host/CPU-side logic and a single `channel` instance.

## Interface
Parameters:
- `DEPTH`, 8 — program store entries (power of two, 2..256); `AW = $clog2(DEPTH)`.
- `START_TIMEOUT`, 32 — cycles allowed after `chan_start` for the channel to leave idle.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ccw_wr_en`  in  1  program store write strobe; honoured only in IDLE.
- `ccw_wr_addr`  in  AW  store index.
- `ccw_wr_data`  in  24  {flags[7:0], command[7:0], count[7:0]}; flags[0]=CC (command chain), flags[1]=SLI (suppress length indication).
- `device_address`  in  8  device address, sampled on `go`.
- `go`  in  1  one-cycle pulse; starts the program at index 0; ignored unless IDLE.
- `busy`  out  1  high from the cycle after accepted `go` through the `done` cycle.
- `done`  out  1  one-cycle pulse at program end.
- `err`  out  4  sticky until next `go`: [0] no start, [1] status error, [2] incorrect length, [3] chain overrun.
- `last_index`  out  AW  index of the CCW that ended the program.
- `residual`  out  8  unused count of the last CCW.
- `last_status`  out  8  status byte of the last CCW.
- `chan_address`, `chan_command`  out  8 each  to `channel` `address`/`command`.
- `chan_start`, `chan_stop`  out  1 each  to `channel` `start`/`stop`.
- `chan_idle`  in  1  high while `channel` is in STATE_IDLE.
- `chan_status`  in  8  ending status; valid on the cycle `chan_idle` rises.
- `host_send_tvalid` in / `host_send_tready` out  1 each  write-data stream from host (data passes straight through to `channel`).
- `chan_send_tvalid` out / `chan_send_tready` in  1 each  to `channel` `data_send_*`.
- `chan_recv_tvalid` in / `chan_recv_tready` out  1 each  from `channel` `data_recv_*`.
- `host_recv_tvalid` out / `host_recv_tready` in  1 each  read-data stream to host.

## Operation
- States: IDLE, FETCH, START, WAIT_BUSY, XFER, END.
- IDLE: `go` latches `device_address`, clears `err`, index:=0 -> FETCH.
- FETCH: store read is registered; CCW lands in `cur_flags/cur_cmd/count` -> START.
- START: `chan_start`=1 for exactly this cycle; timeout counter cleared -> WAIT_BUSY.
- WAIT_BUSY: `chan_idle`=0 -> XFER; counter reaching START_TIMEOUT -> `err[0]`=1, END.
- XFER: streams forwarded only while count≠0: `chan_send_tvalid=host_send_tvalid&nz`, `host_send_tready=chan_send_tready&nz`, `host_recv_tvalid=chan_recv_tvalid&nz`, `chan_recv_tready=host_recv_tready&nz`. Each completed beat on either channel-side handshake decrements count (8-bit, never below 0). When count=0 and (`chan_send_tready` | `chan_recv_tvalid`), `chan_stop` pulses one cycle (registered) and repeats every cycle the condition holds. `chan_idle` rising -> capture `chan_status` -> END.
- END: evaluate in priority order: status lacks CE(0x08)&DE(0x04) or has busy(0x10)/UC(0x02)/UE(0x01) -> `err[1]`; count≠0 and SLI=0 -> `err[2]`. Any err set, or CC=0 -> `done`, IDLE. Else index=DEPTH-1 -> `err[3]`, `done`, IDLE. Else index+1 -> FETCH.
- `residual`, `last_status`, and `last_index` update at END; no-start case reports `last_status`=0 and `residual`=loaded count.

## Timing
- Reset values: all outputs 0; state IDLE; store contents not reset.
- `go` at cycle n: `busy` n+1, `chan_start` n+2.
- `chan_address/chan_command` stable from START through END.
- Pass-through paths are combinational (0-cycle); `chan_stop` is 1-cycle registered.
- Chaining: END->FETCH->START, i.e. the next `chan_start` comes 3 cycles after `chan_idle` rises.
- Reset mid-program: `chan_start`/`chan_stop`/`*_tvalid`/`*_tready` drop immediately; no `done`.

## Test plan
- Write CCW0={00,02,06}, `go` to address 0x1a, CU supplies 16 bytes -> 6 host beats, `chan_stop` seen, `done`, `err`=0, `residual`=0.
- READ count 16, CU supplies 6 bytes, SLI=0 -> `err[2]`=1, `residual`=10; repeat with SLI=1 -> `err`=0, `residual`=10.
- CCW0={01,01,04} (CC, WRITE), CCW1={00,03,00} (NOP) -> two `chan_start` pulses, 4 send beats, `last_index`=1, `err`=0.
- `chan_idle` held high after start -> `err[0]` after 32 cycles, `done`, `chan_address` 0x10 seen.
- Status 0x10 (busy) -> `err[1]`, chain not followed; CC set on all DEPTH entries -> `err[3]`, `last_index`=7.
- Assert `reset` during XFER -> all outputs 0 within the same cycle, `go` accepted afterward.

Source files
------------

// File: rtl/ccw_sequencer.sv
// ccw_sequencer
// Runs a short channel program of chained CCWs against a single channel block.
// Each CCW is fetched from a local program store and issued to the channel via
// address, command and a start pulse. While the CCW is active, the data streams
// between the host and the channel are passed through and counted. At the end of
// each CCW the block evaluates the ending status, then either chains to the next
// CCW or finishes with a residual count and error flags.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   ccw_wr_en/addr/data             program store write port (IDLE only);
//                                   data = {flags, command, count},
//                                   flags[0]=CC, flags[1]=SLI
//   device_address, go              program launch (go is a one-cycle pulse)
//   busy, done, err, last_index,
//   residual, last_status           program result and progress
//   chan_address, chan_command,
//   chan_start, chan_stop           channel control
//   chan_idle, chan_status          channel state and ending status
//   host_send_*, chan_send_*        write-data stream, host -> channel
//   chan_recv_*, host_recv_*        read-data stream, channel -> host
//
// Stream handshakes: a beat completes on a rising clock edge when tvalid and
// tready are both high. The producer may not drop tvalid on its own; the consumer
// may change tready freely. This block only gates both directions of each stream
// with "XFER and count != 0", and does so combinationally.
// Internal FSM state is held in 'state' so checkers can observe it.
module ccw_sequencer #(
    parameter int DEPTH         = 8,
    parameter int START_TIMEOUT = 32,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ccw_wr_en,
    input  logic [AW-1:0] ccw_wr_addr,
    input  logic [23:0]   ccw_wr_data,
    input  logic [7:0]    device_address,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic [3:0]    err,
    output logic [AW-1:0] last_index,
    output logic [7:0]    residual,
    output logic [7:0]    last_status,
    output logic [7:0]    chan_address,
    output logic [7:0]    chan_command,
    output logic          chan_start,
    output logic          chan_stop,
    input  logic          chan_idle,
    input  logic [7:0]    chan_status,
    input  logic          host_send_tvalid,
    output logic          host_send_tready,
    output logic          chan_send_tvalid,
    input  logic          chan_send_tready,
    input  logic          chan_recv_tvalid,
    output logic          chan_recv_tready,
    output logic          host_recv_tvalid,
    input  logic          host_recv_tready
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_WAIT_BUSY, S_XFER, S_END
    } state_t;

    state_t        state;
    logic [23:0]   store [DEPTH];
    logic [AW-1:0] index;
    logic [7:0]    cur_flags;
    logic [7:0]    cur_cmd;
    logic [7:0]    count;
    logic [7:0]    cur_status;
    logic [31:0]   tmo_cnt;

    // The program store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ccw_wr_en && state == S_IDLE) begin
            store[ccw_wr_addr] <= ccw_wr_data;
        end
    end

    // Streams flow only while a CCW is active and still has count remaining.
    logic xfer_en;
    assign xfer_en          = (state == S_XFER) && (count != 8'd0);
    assign chan_send_tvalid = host_send_tvalid & xfer_en;
    assign host_send_tready = chan_send_tready & xfer_en;
    assign host_recv_tvalid = chan_recv_tvalid & xfer_en;
    assign chan_recv_tready = host_recv_tready & xfer_en;
    assign chan_command     = cur_cmd;

    logic send_fire, recv_fire;
    assign send_fire = chan_send_tvalid & chan_send_tready;
    assign recv_fire = chan_recv_tvalid & chan_recv_tready;

    // Both directions can complete a beat in the same cycle; saturate at zero.
    logic [7:0] count_next;
    always_comb begin
        count_next = count;
        if (send_fire && recv_fire) begin
            count_next = (count > 8'd1) ? count - 8'd2 : 8'd0;
        end else if (send_fire || recv_fire) begin
            count_next = count - 8'd1;
        end
    end

    // Ending status check. A no-start ending (err[0]) has no status to judge.
    logic       status_bad, len_bad;
    logic [3:0] end_err;
    assign status_bad = ((cur_status & 8'h0C) != 8'h0C) || ((cur_status & 8'h13) != 8'h00);
    assign len_bad    = (count != 8'd0) && !cur_flags[1];
    assign end_err    = err[0] ? err : (err | {1'b0, len_bad, status_bad, 1'b0});

    // Flag bits above SLI are reserved and carry no function here.
    logic unused_flags;
    assign unused_flags = ^cur_flags[7:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 4'd0;
            last_index   <= '0;
            residual     <= 8'd0;
            last_status  <= 8'd0;
            chan_address <= 8'd0;
            chan_start   <= 1'b0;
            chan_stop    <= 1'b0;
            index        <= '0;
            cur_flags    <= 8'd0;
            cur_cmd      <= 8'd0;
            count        <= 8'd0;
            cur_status   <= 8'd0;
            tmo_cnt      <= 32'd0;
        end else begin
            done       <= 1'b0;
            chan_start <= 1'b0;
            chan_stop  <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (go) begin
                        busy         <= 1'b1;
                        chan_address <= device_address;
                        err          <= 4'd0;
                        index        <= '0;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    {cur_flags, cur_cmd, count} <= store[index];
                    // Registered so the pulse is high exactly during START.
                    chan_start <= 1'b1;
                    state      <= S_START;
                end
                S_START: begin
                    tmo_cnt <= 32'd0;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!chan_idle) begin
                        state <= S_XFER;
                    end else if (tmo_cnt == 32'(START_TIMEOUT - 1)) begin
                        err[0]     <= 1'b1;
                        cur_status <= 8'd0;
                        state      <= S_END;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_XFER: begin
                    count <= count_next;
                    if (chan_idle) begin
                        cur_status <= chan_status;
                        state      <= S_END;
                    end else begin
                        // Count exhausted while the channel still offers or wants data.
                        chan_stop <= (count == 8'd0) && (chan_send_tready || chan_recv_tvalid);
                    end
                end
                S_END: begin
                    err         <= end_err;
                    residual    <= count;
                    last_status <= cur_status;
                    last_index  <= index;
                    if (end_err != 4'd0 || !cur_flags[0]) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (index == AW'(DEPTH - 1)) begin
                        err[3] <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccw_sequencer.sv
module tb_ccw_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ccw_wr_en;
  logic [2:0]  ccw_wr_addr;
  logic [23:0] ccw_wr_data;
  logic [7:0]  device_address;
  logic        go;
  logic        busy, done;
  logic [3:0]  err;
  logic [2:0]  last_index;
  logic [7:0]  residual, last_status, chan_address, chan_command;
  logic        chan_start, chan_stop;
  logic        chan_idle;
  logic [7:0]  chan_status;
  logic        host_send_tvalid, host_send_tready;
  logic        chan_send_tvalid, chan_send_tready;
  logic        chan_recv_tvalid, chan_recv_tready;
  logic        host_recv_tvalid, host_recv_tready;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor counters, written only by the monitor process
  int send_cnt = 0, hrecv_cnt = 0, stop_cnt = 0, start_cnt = 0, done_cnt = 0;
  int s0, h0, p0, t0, d0, cyc;

  ccw_sequencer #(.DEPTH(8), .START_TIMEOUT(32)) dut (
    .clk(clk), .reset(reset),
    .ccw_wr_en(ccw_wr_en), .ccw_wr_addr(ccw_wr_addr), .ccw_wr_data(ccw_wr_data),
    .device_address(device_address), .go(go),
    .busy(busy), .done(done), .err(err), .last_index(last_index),
    .residual(residual), .last_status(last_status),
    .chan_address(chan_address), .chan_command(chan_command),
    .chan_start(chan_start), .chan_stop(chan_stop),
    .chan_idle(chan_idle), .chan_status(chan_status),
    .host_send_tvalid(host_send_tvalid), .host_send_tready(host_send_tready),
    .chan_send_tvalid(chan_send_tvalid), .chan_send_tready(chan_send_tready),
    .chan_recv_tvalid(chan_recv_tvalid), .chan_recv_tready(chan_recv_tready),
    .host_recv_tvalid(host_recv_tvalid), .host_recv_tready(host_recv_tready)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (host_recv_tvalid && host_recv_tready) hrecv_cnt++;
    if (chan_send_tvalid && chan_send_tready) send_cnt++;
    if (chan_stop) stop_cnt++;
    if (chan_start) start_cnt++;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {17'd0, busy, done, err, last_index, residual, last_status, chan_address,
            chan_command, chan_start, chan_stop, host_send_tready, chan_send_tvalid,
            chan_recv_tready, host_recv_tvalid};
  endfunction

  // driver tasks
  task automatic wr_ccw(input logic [2:0] addr, input logic [23:0] data);
    ccw_wr_en = 1'b1; ccw_wr_addr = addr; ccw_wr_data = data;
    @(posedge clk); #1;
    ccw_wr_en = 1'b0;
  endtask

  task automatic start_prog(input logic [7:0] addr);
    device_address = addr;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check_eq("busy_after_go", busy, 1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!chan_start && n < 100);
  endtask

  // Control-unit model: wait for start, go busy, move up to 'supply' bytes,
  // end early on chan_stop, then present idle with the given status.
  task automatic cu_run(input logic [7:0] exp_cmd, input logic [7:0] exp_addr,
                        input int exp_lat, input bit respond, input int supply,
                        input bit is_write, input logic [7:0] status);
    int n;
    int moved;
    bit stop_seen;
    wait_start(n);
    check_eq("start_seen", chan_start, 1);
    if (exp_lat != 0) check_eq("start_latency", n, exp_lat);
    check_eq("chan_command", chan_command, exp_cmd);
    check_eq("chan_address", chan_address, exp_addr);
    @(posedge clk); #1;
    if (respond) begin
      chan_idle = 1'b0;
      moved = 0;
      stop_seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        chan_recv_tvalid = !is_write && (moved < supply);
        chan_send_tready = is_write && (moved < supply);
        @(negedge clk);
        if (chan_recv_tvalid && chan_recv_tready) moved++;
        if (chan_send_tready && chan_send_tvalid) moved++;
        if (chan_stop) stop_seen = 1'b1;
        @(posedge clk); #1;
        if (stop_seen || moved >= supply) break;
      end
      chan_recv_tvalid = 1'b0;
      chan_send_tready = 1'b0;
      chan_status = status;
      chan_idle = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", seen, 1);
    check_eq("busy_at_done", busy, 1);
    @(posedge clk); #1;
    check_eq("busy_after_done", busy, 0);
  endtask

  task automatic snap();
    s0 = send_cnt; h0 = hrecv_cnt; p0 = stop_cnt; t0 = start_cnt; d0 = done_cnt;
  endtask

  initial begin
    reset = 1'b1;
    ccw_wr_en = 1'b0; ccw_wr_addr = '0; ccw_wr_data = '0;
    device_address = '0; go = 1'b0;
    chan_idle = 1'b1; chan_status = '0;
    host_send_tvalid = 1'b1; host_recv_tready = 1'b1;
    chan_send_tready = 1'b0; chan_recv_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", out_vec(), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // read 6, CU offers 16: stop after 6 beats
    wr_ccw(3'd0, {8'h00, 8'h02, 8'h06});
    snap();
    start_prog(8'h1a);
    cu_run(8'h02, 8'h1a, 2, 1'b1, 16, 1'b0, 8'h0C);
    wait_done(20);
    check_eq("t1_err", err, 4'b0000);
    check_eq("t1_residual", residual, 8'd0);
    check_eq("t1_host_beats", hrecv_cnt - h0, 6);
    check_eq("t1_stop_seen", (stop_cnt - p0) > 0, 1);
    check_eq("t1_last_status", last_status, 8'h0C);

    // read 16, CU gives 6, SLI=0 -> incorrect length
    wr_ccw(3'd0, {8'h00, 8'h02, 8'h10});
    start_prog(8'h1a);
    cu_run(8'h02, 8'h1a, 2, 1'b1, 6, 1'b0, 8'h0C);
    wait_done(20);
    check_eq("t2_err", err, 4'b0100);
    check_eq("t2_residual", residual, 8'd10);

    // same with SLI=1 -> no error
    wr_ccw(3'd0, {8'h02, 8'h02, 8'h10});
    start_prog(8'h1a);
    cu_run(8'h02, 8'h1a, 2, 1'b1, 6, 1'b0, 8'h0C);
    wait_done(20);
    check_eq("t2s_err", err, 4'b0000);
    check_eq("t2s_residual", residual, 8'd10);

    // chained WRITE 4 then NOP
    wr_ccw(3'd0, {8'h01, 8'h01, 8'h04});
    wr_ccw(3'd1, {8'h00, 8'h03, 8'h00});
    snap();
    start_prog(8'h30);
    cu_run(8'h01, 8'h30, 2, 1'b1, 8, 1'b1, 8'h0C);
    cu_run(8'h03, 8'h30, 4, 1'b1, 0, 1'b0, 8'h0C);
    wait_done(20);
    check_eq("t3_starts", start_cnt - t0, 2);
    check_eq("t3_send_beats", send_cnt - s0, 4);
    check_eq("t3_last_index", last_index, 3'd1);
    check_eq("t3_err", err, 4'b0000);

    // channel never leaves idle -> no-start
    wr_ccw(3'd0, {8'h00, 8'h02, 8'h05});
    start_prog(8'h10);
    cu_run(8'h02, 8'h10, 2, 1'b0, 0, 1'b0, 8'h00);
    wait_done(100);
    check_eq("t4_err", err, 4'b0001);
    check_eq("t4_last_status", last_status, 8'h00);
    check_eq("t4_residual", residual, 8'd5);

    // busy status stops the chain
    wr_ccw(3'd0, {8'h01, 8'h03, 8'h00});
    snap();
    start_prog(8'h40);
    cu_run(8'h03, 8'h40, 2, 1'b1, 0, 1'b0, 8'h10);
    wait_done(20);
    check_eq("t5_err", err, 4'b0010);
    check_eq("t5_starts", start_cnt - t0, 1);
    check_eq("t5_last_status", last_status, 8'h10);

    // CC on every entry -> chain overrun at the last index
    for (int i = 0; i < 8; i++) wr_ccw(3'(i), {8'h01, 8'h03, 8'h00});
    snap();
    start_prog(8'h41);
    for (int i = 0; i < 8; i++) cu_run(8'h03, 8'h41, (i == 0) ? 2 : 4, 1'b1, 0, 1'b0, 8'h0C);
    wait_done(20);
    check_eq("t6_err", err, 4'b1000);
    check_eq("t6_last_index", last_index, 3'd7);
    check_eq("t6_starts", start_cnt - t0, 8);

    // reset in the middle of a transfer
    wr_ccw(3'd0, {8'h00, 8'h02, 8'h10});
    start_prog(8'h21);
    wait_start(cyc);
    check_eq("t7_start_seen", chan_start, 1);
    @(posedge clk); #1;
    chan_idle = 1'b0;
    chan_recv_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t7_xfer_active", chan_recv_tready, 1);
    snap();
    reset = 1'b1;
    #1;
    check_eq("t7_outputs_zero", out_vec(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chan_recv_tvalid = 1'b0;
    chan_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t7_no_done", done_cnt - d0, 0);
    snap();
    start_prog(8'h22);
    cu_run(8'h02, 8'h22, 2, 1'b1, 16, 1'b0, 8'h0C);
    wait_done(20);
    check_eq("t7_err", err, 4'b0000);
    check_eq("t7_residual", residual, 8'd0);
    check_eq("t7_host_beats", hrecv_cnt - h0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
